// File: rtl/rf_write_arbiter_pkg.sv
// Shared register-file definitions for the write-back arbiter.
// Holds the address width, register count and zero-register constant.
package rf_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [NUM_REGS-1:0]   reg_mask_t;

    localparam reg_addr_t ZERO_REG = '0;

    // Register 0 is hard-wired, so it never produces a mask bit.
    function automatic reg_mask_t reg_onehot(input reg_addr_t addr, input logic en);
        reg_onehot = '0;
        if (en && (addr != ZERO_REG)) begin
            reg_onehot[addr] = 1'b1;
        end
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first requester strictly after ptr_i, wrapping around.
// Purely combinational; the caller owns the pointer register.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [PTR_W-1:0] grant_idx_o,
    output logic             grant_valid_o
);

    int   idx;
    logic found;

    // NOTE: every combinational output gets a default before any branch so no latch is inferred.
    always_comb begin
        grant_o       = '0;
        grant_idx_o   = '0;
        grant_valid_o = 1'b0;
        idx           = 0;
        found         = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && req_i[idx]) begin
                found         = 1'b1;
                grant_o[idx]  = 1'b1;
                grant_idx_o   = PTR_W'(idx);
                grant_valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Arbitrates N_REQ write-back requesters onto one registered RF write port
// and keeps a pending-write scoreboard for the issue stage.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int N_REQ = 3,
    parameter int DW    = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [REG_ADDR_W*N_REQ-1:0] req_addr,
    input  logic [DW*N_REQ-1:0]         req_data,
    output logic [N_REQ-1:0]            req_ready,
    input  logic                        hold,
    input  logic                        rsv_valid,
    input  logic [REG_ADDR_W-1:0]       rsv_addr,
    output logic                        wen,
    output logic [REG_ADDR_W-1:0]       wa,
    output logic [DW-1:0]               wd,
    output logic [NUM_REGS-1:0]         pending
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_GRANT_RST = PTR_W'(N_REQ - 1);

    logic [PTR_W-1:0] last_grant_q, last_grant_d;
    logic             wen_q, wen_d;
    reg_addr_t        wa_q, wa_d;
    logic [DW-1:0]    wd_q, wd_d;
    reg_mask_t        pending_q, pending_d;

    logic [N_REQ-1:0] arb_req;
    logic [N_REQ-1:0] grant;
    logic [PTR_W-1:0] grant_idx;
    logic             transfer;
    reg_addr_t        win_addr;
    logic [DW-1:0]    win_data;

    // Nothing is offered while held or while reset is asserted.
    assign arb_req = req_valid & {N_REQ{reset & ~hold}};

    rr_arbiter #(
        .N     (N_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req_i         (arb_req),
        .ptr_i         (last_grant_q),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (transfer)
    );

    assign req_ready = grant;

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                win_addr = req_addr[REG_ADDR_W*i +: REG_ADDR_W];
                win_data = req_data[DW*i +: DW];
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        wen_d        = 1'b0;
        wa_d         = wa_q;
        wd_d         = wd_q;
        if (transfer) begin
            last_grant_d = grant_idx;
            wa_d         = win_addr;
            wd_d         = win_data;
            wen_d        = (win_addr != ZERO_REG);
        end
        // Clear first, then set, so a same-edge reservation wins.
        pending_d = (pending_q & ~reg_onehot(win_addr, transfer))
                  | reg_onehot(rsv_addr, rsv_valid);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like any other state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= LAST_GRANT_RST;
            wen_q        <= 1'b0;
            wa_q         <= '0;
            wd_q         <= '0;
            pending_q    <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wen_q        <= wen_d;
            wa_q         <= wa_d;
            wd_q         <= wd_d;
            pending_q    <= pending_d;
        end
    end

    assign wen     = wen_q;
    assign wa      = wa_q;
    assign wd      = wd_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus random checks of rf_write_arbiter against a behavioural model.
module tb_rf_write_arbiter;

    localparam int N  = 3;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [N-1:0]      req_valid;
    logic [5*N-1:0]    req_addr;
    logic [DW*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              hold;
    logic              rsv_valid;
    logic [4:0]        rsv_addr;
    logic              wen;
    logic [4:0]        wa;
    logic [DW-1:0]     wd;
    logic [31:0]       pending;

    always #5 clock = ~clock;

    rf_write_arbiter #(.N_REQ(N), .DW(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .hold      (hold),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .wen       (wen),
        .wa        (wa),
        .wd        (wd),
        .pending   (pending)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model state
    int          m_last;
    logic [31:0] m_pend;
    logic        m_wen;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;

    // Stimulus state
    logic [N-1:0] v;
    logic [4:0]   a [N];
    logic [31:0]  d [N];
    logic         h;
    logic         rv;
    logic [4:0]   ra;
    int           wait_cnt [N];
    int           last_w;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last = N - 1;
        m_pend = '0;
        m_wen  = 1'b0;
        m_wa   = '0;
        m_wd   = '0;
    endtask

    function automatic int winner();
        int i;
        if (h) return -1;
        for (int k = 1; k <= N; k++) begin
            i = (m_last + k) % N;
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic drive();
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_addr[5*i +: 5]   = a[i];
            req_data[DW*i +: DW] = d[i];
        end
        hold      = h;
        rsv_valid = rv;
        rsv_addr  = ra;
    endtask

    task automatic model_edge(input int w);
        logic [31:0] clr;
        logic [31:0] set;
        clr   = '0;
        set   = '0;
        m_wen = 1'b0;
        if (w >= 0) begin
            m_last = w;
            if (a[w] != 5'd0) begin
                m_wen    = 1'b1;
                m_wa     = a[w];
                m_wd     = d[w];
                clr[a[w]] = 1'b1;
            end
        end
        if (rv && ra != 5'd0) set[ra] = 1'b1;
        m_pend = (m_pend & ~clr) | set;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".wen"}, 64'(wen), 64'(m_wen));
        if (m_wen) begin
            chk({tag, ".wa"}, 64'(wa), 64'(m_wa));
            chk({tag, ".wd"}, 64'(wd), 64'(m_wd));
        end
        chk({tag, ".pending"}, 64'(pending), 64'(m_pend));
    endtask

    // One cycle starting just after a falling edge.
    task automatic cycle(input string tag, output int w);
        logic [N-1:0] er;
        drive();
        #1;
        w  = winner();
        er = (w >= 0) ? (N'(1) << w) : '0;
        chk({tag, ".ready"}, 64'(req_ready), 64'(er));
        @(posedge clock);
        model_edge(w);
        #1;
        check_outputs(tag);
        @(negedge clock);
    endtask

    initial begin
        v  = '0;
        h  = 1'b0;
        rv = 1'b0;
        ra = '0;
        for (int i = 0; i < N; i++) begin
            a[i] = '0;
            d[i] = '0;
            wait_cnt[i] = 0;
        end
        model_reset();

        // Reset: ready must stay low even with every requester valid.
        v = 3'b111;
        a[0] = 5'd5; a[1] = 5'd6; a[2] = 5'd7;
        d[0] = 32'hAAAA_AAAA; d[1] = 32'hBBBB_BBBB; d[2] = 32'hCCCC_CCCC;
        drive();
        #1;
        chk("rst.ready", 64'(req_ready), 64'd0);
        chk("rst.wen", 64'(wen), 64'd0);
        chk("rst.wa", 64'(wa), 64'd0);
        chk("rst.wd", 64'(wd), 64'd0);
        chk("rst.pending", 64'(pending), 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // All three valid: grants rotate 0,1,2,0.
        for (int k = 0; k < 4; k++) cycle("rr", last_w);

        // Only requester 2 for four cycles, then requester 0 joins.
        v = 3'b100; a[2] = 5'd9; d[2] = 32'h9999_0009;
        for (int k = 0; k < 4; k++) cycle("solo2", last_w);
        v = 3'b101; a[0] = 5'd3; d[0] = 32'h0303_0303;
        cycle("join0", last_w);
        chk("join0.winner", 64'(last_w), 64'd0);

        // Zero-register write is accepted but not written.
        v = 3'b010; a[1] = 5'd0; d[1] = 32'hFFFF_FFFF;
        cycle("zero", last_w);

        // Reservation/clear interplay on register 12.
        v = 3'b000; rv = 1'b1; ra = 5'd12;
        cycle("rsv12", last_w);
        v = 3'b001; a[0] = 5'd12; d[0] = 32'h1212_1212;
        cycle("setwin", last_w);
        rv = 1'b0;
        cycle("clr12", last_w);
        v = 3'b000;
        cycle("idle", last_w);

        // Hold with all valid, then release.
        v = 3'b111; a[0] = 5'd1; a[1] = 5'd2; a[2] = 5'd4; h = 1'b1;
        for (int k = 0; k < 3; k++) cycle("hold", last_w);
        h = 1'b0;
        cycle("release", last_w);

        // Reset pulse between the transfer edge and the following falling edge.
        v = 3'b001; a[0] = 5'd3; d[0] = 32'hDEAD_BEEF; rv = 1'b1; ra = 5'd20;
        drive();
        #1;
        chk("midrst.ready", 64'(req_ready), 64'(N'(1) << winner()));
        @(posedge clock);
        model_edge(winner());
        #1;
        check_outputs("midrst.pre");
        reset = 1'b0;
        #1;
        model_reset();
        chk("midrst.ready0", 64'(req_ready), 64'd0);
        check_outputs("midrst.post");
        chk("midrst.wa", 64'(wa), 64'd0);
        #1;
        reset = 1'b1;
        rv = 1'b0;
        @(negedge clock);
        v = 3'b111;
        cycle("after_rst", last_w);
        chk("after_rst.winner", 64'(last_w), 64'd0);

        // Random traffic; requests stay stable until granted.
        v = '0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 400; n++) begin
            h  = ($urandom_range(0, 7) == 0);
            rv = $urandom_range(0, 1) == 1;
            ra = 5'($urandom_range(0, 31));
            for (int i = 0; i < N; i++) begin
                if (!v[i] && $urandom_range(0, 1) == 1) begin
                    v[i] = 1'b1;
                    a[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3))
                                                       : 5'($urandom_range(0, 31));
                    d[i] = $urandom;
                    wait_cnt[i] = 0;
                end
            end
            for (int i = 0; i < N; i++) if (v[i] && !h) wait_cnt[i]++;
            cycle("rnd", last_w);
            if (last_w >= 0) begin
                chk("rnd.fair", 64'(wait_cnt[last_w] <= N), 64'd1);
                v[last_w] = 1'b0;
                wait_cnt[last_w] = 0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/rf_write_arbiter.md
RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter: N_REQ, 3, number of write-back requesters sharing the register-file write port.
REQ-002 Parameter: DW, 32, write data width.
REQ-003 clock  in  1  all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  N_REQ  requester i has a write pending.
REQ-006 req_addr  in  5*N_REQ  destination register of requester i, slice [5i+4:5i].
REQ-007 req_data  in  DW*N_REQ  write data of requester i, slice [DW*i+DW-1:DW*i].
REQ-008 req_ready  out  N_REQ  one-hot or zero; write of requester i accepted this cycle.
REQ-009 hold  in  1  when high, no request is accepted.
REQ-010 rsv_valid  in  1  issue stage reserves a destination register.
REQ-011 rsv_addr  in  5  register being reserved.
REQ-012 wen, wa, wd  out  1/5/DW  registered write port to the register file.
REQ-013 pending  out  32  scoreboard; bit r high while register r awaits write-back.

Function
REQ-014 A transfer on requester i SHALL occur on a rising edge where req_valid[i] && req_ready[i].
REQ-015 req_ready SHALL be combinational from req_valid, hold and the round-robin pointer, with at most one bit set.
REQ-016 Requesters SHALL hold valid, addr and data stable until ready; the arbiter does not buffer rejected requests.
REQ-017 The winner SHALL be the first valid requester, searching upward from (last_grant+1) mod N_REQ with wrap-around.
REQ-018 last_grant SHALL update only on a transfer; idle cycles leave it unchanged.
REQ-019 When hold=1, req_ready SHALL be all zero, and last_grant and wen outputs SHALL follow as on an idle cycle.
REQ-020 On a transfer, wen/wa/wd SHALL be loaded from the winner on that rising edge and held for exactly one cycle; the register file captures on the following falling edge (half-cycle latency).
REQ-021 With no transfer, wen SHALL be 0 on the next edge; wa/wd SHALL hold their previous values.
REQ-022 A transfer with addr 0 SHALL be accepted (ready=1) but SHALL drive wen=0.
REQ-023 Every continuously valid requester SHALL be granted within N_REQ consecutive non-hold cycles.
REQ-024 On rising edge with rsv_valid=1 and rsv_addr!=0, pending[rsv_addr] SHALL be set.
REQ-025 On rising edge with a transfer to addr r!=0, pending[r] SHALL be cleared.
REQ-026 If the same register is set and cleared on one edge, set SHALL win.
REQ-027 pending[0] SHALL always be 0.
REQ-028 Clears to registers not pending SHALL be harmless (bit stays 0).

Reset
REQ-029 On reset=0, asynchronously: wen=0, wa=0, wd=0, pending=0, last_grant=N_REQ-1, so requester 0 has first priority.
REQ-030 During reset, req_ready SHALL be all zero.
REQ-031 Reset assertion mid-transfer SHALL discard that transfer; no write reaches the register file.
REQ-032 After deassertion, the first rising edge SHALL behave as a normal cycle.

Structure
REQ-033 The shared package SHALL hold REG_ADDR_W=5, NUM_REGS=32 and the zero-register index constant.
REQ-034 The round-robin grant logic SHALL be one sub-module, rr_arbiter (request vector, pointer -> one-hot grant); scoreboard and output register stay in the top.

Verification
REQ-035 Reset then req_valid=3'b111, addrs 5/6/7, data A/B/C held -> grants 0,1,2,0 on successive cycles; wen=1 with (5,A),(6,B),(7,C) one cycle after each grant.
REQ-036 Only requester 2 valid for 4 cycles, addr 9 -> ready[2]=1 every cycle; requester 0 then raised -> granted on the next cycle.
REQ-037 Requester 1 writes addr 0 data FFFFFFFF -> ready[1]=1, wen stays 0, pending unchanged.
REQ-038 rsv addr 12 -> pending[12]=1; transfer to 12 alongside rsv 12 on the same edge -> pending[12] stays 1; next transfer to 12 -> pending[12]=0.
REQ-039 hold=1 for 3 cycles with all valid -> ready=0 and wen=0 throughout; after release, the grant resumes at the requester after last_grant.
REQ-040 Reset pulsed low between transfer edge and falling edge -> wen=0 immediately, pending=0, next grant goes to requester 0.
